exec_unit_p: RTL and testbench

Parametrised successor to the single-cycle execute stage of the CS220A MIPS-subset datapath. It accepts one decoded instruction per handshake, computes the ALU result and the next PC, and reports illegal opcodes by halting. Data width, PC width, reset PC and end-of-program PC are parameters. It adds an issue/ready handshake, a HALT state and an optional multi-cycle multiply. It sits between the decode/register-read stage and writeback/memory, and owns the architectural PC.

---
 rtl/exec_unit_p_if.sv | 34 +++
 rtl/exec_unit_p.sv | 171 +++++++++++++++++
 tb/tb_exec_unit_p.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_unit_p_if.sv
// exec_unit_p_if: issue/result bundle between decode, the execute stage and writeback
// Parameters: DATA_W operand/result width, PC_W program counter width.
// Signals: issue_valid/issue_ready handshake with opcode, func, rsv, rtv, imm, jt;
//          result, result_valid, pc, busy, halted, instruction_invalid back out.
// Modports: master = decode/register-read side, slave = execute stage.
interface exec_unit_p_if #(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8
);
    logic              issue_valid;
    logic              issue_ready;
    logic [5:0]        opcode;
    logic [5:0]        func;
    logic [DATA_W-1:0] rsv;
    logic [DATA_W-1:0] rtv;
    logic [15:0]       imm;
    logic [25:0]       jt;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic [PC_W-1:0]   pc;
    logic              busy;
    logic              halted;
    logic              instruction_invalid;

    modport master (
        output issue_valid, opcode, func, rsv, rtv, imm, jt,
        input  issue_ready, result, result_valid, pc, busy, halted, instruction_invalid
    );

    modport slave (
        input  issue_valid, opcode, func, rsv, rtv, imm, jt,
        output issue_ready, result, result_valid, pc, busy, halted, instruction_invalid
    );
endinterface

// File: rtl/exec_unit_p.sv
// exec_unit_p: MIPS-subset execute stage owning the PC, with issue handshake, HALT and optional multiply
// Ports: clk, rst_n (async active-low), bus (exec_unit_p_if.slave: issue handshake in,
//        result/result_valid/pc/busy/halted/instruction_invalid out).
// Config macro: EXEC_MUL_EN enables R-type mul (func 0x18) as a DATA_W-cycle shift-add.
module exec_unit_p #(
    parameter int DATA_W   = 8,
    parameter int PC_W     = 8,
    parameter int RESET_PC = 12,
    parameter int MAX_PC   = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    exec_unit_p_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HALT `ifdef EXEC_MUL_EN , MUL `endif} state_t;

    localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] PC_END = PC_W'(MAX_PC);

    state_t            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [DATA_W-1:0] result_q;
    logic              rv_q;
    logic              inv_q;

    logic [DATA_W-1:0] immx;
    logic [DATA_W-1:0] res_d;
    logic [PC_W-1:0]   pc1;
    logic [PC_W-1:0]   boff;
    logic [PC_W-1:0]   pc_d;
    logic              legal;
    logic              wr;

    // Immediate is sign-extended before slicing, so narrow widths see plain truncation
    assign immx = DATA_W'($signed(bus.imm));
    assign boff = PC_W'($signed(bus.imm));
    assign pc1  = pc_q + PC_W'(1);

`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(DATA_W);
    logic [DATA_W-1:0] mcand_q;
    logic [DATA_W-1:0] mplier_q;
    logic [DATA_W-1:0] acc_q;
    logic [DATA_W-1:0] acc_d;
    logic [CW-1:0]     cnt_q;
    logic              mul_go;
    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        legal = 1'b1;
        wr    = 1'b0;
        res_d = result_q;
        pc_d  = pc1;
`ifdef EXEC_MUL_EN
        mul_go = 1'b0;
`endif
        case (bus.opcode)
            6'h09, 6'h23: begin
                wr    = 1'b1;
                res_d = bus.rsv + immx;
            end
            6'h04: pc_d = (bus.rsv == bus.rtv) ? pc_q + boff : pc1;
            6'h05: pc_d = (bus.rsv != bus.rtv) ? pc_q + boff : pc1;
            6'h02: pc_d = bus.jt[PC_W-1:0];
            6'h03: begin
                wr    = 1'b1;
                res_d = DATA_W'(pc1);
                pc_d  = bus.jt[PC_W-1:0];
            end
            6'h00: begin
                wr = 1'b1;
                case (bus.func)
                    6'h21: res_d = bus.rsv + bus.rtv;
                    6'h23: res_d = bus.rsv - bus.rtv;
                    6'h24: res_d = bus.rsv & bus.rtv;
                    6'h25: res_d = bus.rsv | bus.rtv;
                    6'h2a: res_d = DATA_W'($signed(bus.rsv) < $signed(bus.rtv));
                    6'h2b: res_d = DATA_W'(bus.rsv < bus.rtv);
                    6'h08: begin
                        wr   = 1'b0;
                        pc_d = PC_W'(bus.rsv);
                    end
`ifdef EXEC_MUL_EN
                    6'h18: begin
                        wr     = 1'b0;
                        mul_go = 1'b1;
                    end
`endif
                    default: begin
                        wr    = 1'b0;
                        legal = 1'b0;
                    end
                endcase
            end
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= PC_RST;
            result_q <= '0;
            rv_q     <= 1'b0;
            inv_q    <= 1'b0;
`ifdef EXEC_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            rv_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.issue_valid) begin
                    if (!legal) begin
                        pc_q    <= PC_END;
                        inv_q   <= 1'b1;
                        state_q <= HALT;
                    end
`ifdef EXEC_MUL_EN
                    else if (mul_go) begin
                        mcand_q  <= bus.rsv;
                        mplier_q <= bus.rtv;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        state_q  <= MUL;
                    end
`endif
                    else begin
                        pc_q <= pc_d;
                        if (wr) begin
                            result_q <= res_d;
                            rv_q     <= 1'b1;
                        end
                        if (pc_d == PC_END) state_q <= HALT;
                    end
                end
`ifdef EXEC_MUL_EN
                // One partial product per cycle; the last one lands straight in result
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(DATA_W - 1)) begin
                        result_q <= acc_d;
                        rv_q     <= 1'b1;
                        pc_q     <= pc1;
                        state_q  <= (pc1 == PC_END) ? HALT : IDLE;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.issue_ready         = state_q == IDLE;
    assign bus.result              = result_q;
    assign bus.result_valid        = rv_q;
    assign bus.pc                  = pc_q;
    assign bus.halted              = state_q == HALT;
    assign bus.instruction_invalid = inv_q;
`ifdef EXEC_MUL_EN
    assign bus.busy = state_q == MUL;
`else
    assign bus.busy = 1'b0;
`endif
endmodule

// File: tb/tb_exec_unit_p.sv
// tb_exec_unit_p: vector table, corner sequences and random checks against a behavioural model
module tb_exec_unit_p;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int fails = 0;

    exec_unit_p_if #(.DATA_W(8), .PC_W(8)) bus ();
    exec_unit_p #(.DATA_W(8), .PC_W(8), .RESET_PC(12), .MAX_PC(14)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          rst;
        logic [5:0]  op, fn;
        logic [7:0]  rs, rt;
        logic [15:0] im;
        logic [25:0] jt;
        logic [7:0]  res;
        bit          rv;
        logic [7:0]  pc;
        bit          h, inv;
    } vec_t;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    task automatic do_reset();
        bus.issue_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic issue(input logic [5:0] op, fn, input logic [7:0] rs, rt,
                         input logic [15:0] im, input logic [25:0] jt);
        bus.issue_valid = 1'b1;
        bus.opcode = op;
        bus.func = fn;
        bus.rsv = rs;
        bus.rtv = rt;
        bus.imm = im;
        bus.jt = jt;
        @(posedge clk);
        #1 bus.issue_valid = 1'b0;
    endtask

    // Architectural effect of one instruction on (pc, result), from the instruction rules
    function automatic void ref_step(input logic [5:0] op, fn, input logic [7:0] rs, rt,
                                     input logic [15:0] im, input logic [25:0] jt,
                                     inout int pc, inout int res, output bit rv, output bit h,
                                     output bit inv);
        int a = int'(rs), b = int'(rt), i = int'(im), t = int'(jt);
        int sa = a > 127 ? a - 256 : a;
        int sb = b > 127 ? b - 256 : b;
        int npc = pc + 1;
        bit ok = 1;
        rv = 0;
        case (op)
            6'h09, 6'h23: begin res = (a + i) & 255; rv = 1; end
            6'h04: if (a == b) npc = pc + (i & 255);
            6'h05: if (a != b) npc = pc + (i & 255);
            6'h02: npc = t & 255;
            6'h03: begin res = (pc + 1) & 255; rv = 1; npc = t & 255; end
            6'h00: case (fn)
                6'h21: begin res = (a + b) & 255; rv = 1; end
                6'h23: begin res = (a - b) & 255; rv = 1; end
                6'h24: begin res = a & b; rv = 1; end
                6'h25: begin res = a | b; rv = 1; end
                6'h2a: begin res = (sa < sb) ? 1 : 0; rv = 1; end
                6'h2b: begin res = (a < b) ? 1 : 0; rv = 1; end
                6'h08: npc = a;
                default: ok = 0;
            endcase
            default: ok = 0;
        endcase
        if (!ok) begin
            pc = 14; inv = 1; h = 1; rv = 0;
        end else begin
            pc = npc & 255; inv = 0; h = (pc == 14);
        end
    endfunction

    vec_t tv[15];
    logic [5:0] opl[9] = '{6'h09, 6'h23, 6'h04, 6'h05, 6'h02, 6'h03, 6'h00, 6'h00, 6'h00};
    logic [5:0] fnl[7] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h08};

    initial begin
        bit seen;
        tv[0]  = '{1, 6'h09, 6'h00, 8'hF0, 8'h00, 16'h0020, 26'h0,  8'h10, 1, 8'd13, 0, 0};
        tv[1]  = '{0, 6'h00, 6'h21, 8'h03, 8'h04, 16'h0000, 26'h0,  8'h07, 1, 8'd14, 1, 0};
        tv[2]  = '{1, 6'h04, 6'h00, 8'h05, 8'h05, 16'hFFFE, 26'h0,  8'h00, 0, 8'd10, 0, 0};
        tv[3]  = '{0, 6'h05, 6'h00, 8'h05, 8'h05, 16'hFFFE, 26'h0,  8'h00, 0, 8'd11, 0, 0};
        tv[4]  = '{0, 6'h03, 6'h00, 8'h00, 8'h00, 16'h0000, 26'h3,  8'd12, 1, 8'd3,  0, 0};
        tv[5]  = '{0, 6'h00, 6'h08, 8'h09, 8'h00, 16'h0000, 26'h0,  8'd12, 0, 8'd9,  0, 0};
        tv[6]  = '{0, 6'h00, 6'h2a, 8'hFF, 8'h01, 16'h0000, 26'h0,  8'h01, 1, 8'd10, 0, 0};
        tv[7]  = '{0, 6'h00, 6'h2b, 8'hFF, 8'h01, 16'h0000, 26'h0,  8'h00, 1, 8'd11, 0, 0};
        tv[8]  = '{0, 6'h00, 6'h23, 8'h02, 8'h05, 16'h0000, 26'h0,  8'hFD, 1, 8'd12, 0, 0};
        tv[9]  = '{0, 6'h00, 6'h24, 8'hF0, 8'h3C, 16'h0000, 26'h0,  8'h30, 1, 8'd13, 0, 0};
        tv[10] = '{0, 6'h00, 6'h25, 8'h0F, 8'h30, 16'h0000, 26'h0,  8'h3F, 1, 8'd14, 1, 0};
        tv[11] = '{1, 6'h3F, 6'h00, 8'h00, 8'h00, 16'h0000, 26'h0,  8'h00, 0, 8'd14, 1, 1};
        tv[12] = '{1, 6'h02, 6'h00, 8'h00, 8'h00, 16'h0000, 26'h20, 8'h00, 0, 8'h20, 0, 0};
        tv[13] = '{0, 6'h23, 6'h00, 8'h10, 8'h00, 16'hFFFF, 26'h0,  8'h0F, 1, 8'h21, 0, 0};
        tv[14] = '{0, 6'h00, 6'h3F, 8'h00, 8'h00, 16'h0000, 26'h0,  8'h0F, 0, 8'd14, 1, 1};
        bus.issue_valid = 1'b0;
        bus.opcode = '0; bus.func = '0; bus.rsv = '0; bus.rtv = '0; bus.imm = '0; bus.jt = '0;

        do_reset();
        chk("rst_pc", bus.pc, 12);
        chk("rst_halted", bus.halted, 0);
        chk("rst_inv", bus.instruction_invalid, 0);
        chk("rst_ready", bus.issue_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rv", bus.result_valid, 0);
        chk("rst_result", bus.result, 0);

        foreach (tv[i]) begin
            if (tv[i].rst) do_reset();
            issue(tv[i].op, tv[i].fn, tv[i].rs, tv[i].rt, tv[i].im, tv[i].jt);
            chk($sformatf("v%0d_result", i), bus.result, tv[i].res);
            chk($sformatf("v%0d_rv", i), bus.result_valid, tv[i].rv);
            chk($sformatf("v%0d_pc", i), bus.pc, tv[i].pc);
            chk($sformatf("v%0d_halted", i), bus.halted, tv[i].h);
            chk($sformatf("v%0d_inv", i), bus.instruction_invalid, tv[i].inv);
            chk($sformatf("v%0d_ready", i), bus.issue_ready, !tv[i].h);
        end

        repeat (3) issue(6'h09, 6'h00, 8'h01, 8'h00, 16'h0001, 26'h0);
        chk("halt_ignore_pc", bus.pc, 14);
        chk("halt_ignore_rv", bus.result_valid, 0);
        chk("halt_ignore_result", bus.result, 8'h0F);
        chk("halt_ignore_inv", bus.instruction_invalid, 1);

        do_reset();
        issue(6'h09, 6'h00, 8'hF0, 8'h00, 16'h0020, 26'h0);
        @(posedge clk);
        #1;
        chk("pulse_rv_drop", bus.result_valid, 0);
        chk("pulse_result_hold", bus.result, 8'h10);

`ifdef EXEC_MUL_EN
        do_reset();
        issue(6'h00, 6'h18, 8'd13, 8'd11, 16'h0, 26'h0);
        chk("mul_busy0", bus.busy, 1);
        chk("mul_ready0", bus.issue_ready, 0);
        for (int i = 1; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("mul_busy%0d", i), bus.busy, 1);
            chk($sformatf("mul_rv%0d", i), bus.result_valid, 0);
        end
        @(posedge clk);
        #1;
        chk("mul_result", bus.result, 8'd143);
        chk("mul_rv", bus.result_valid, 1);
        chk("mul_pc", bus.pc, 13);
        chk("mul_busy_end", bus.busy, 0);
        chk("mul_ready_end", bus.issue_ready, 1);

        do_reset();
        issue(6'h00, 6'h18, 8'd13, 8'd11, 16'h0, 26'h0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("mulrst_busy", bus.busy, 0);
        chk("mulrst_pc", bus.pc, 12);
        chk("mulrst_result", bus.result, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1 seen |= bus.result_valid;
        end
        chk("mulrst_no_rv", seen, 0);
        chk("mulrst_pc_after", bus.pc, 12);
`else
        do_reset();
        issue(6'h00, 6'h18, 8'd13, 8'd11, 16'h0, 26'h0);
        chk("nomul_pc", bus.pc, 14);
        chk("nomul_inv", bus.instruction_invalid, 1);
        chk("nomul_halted", bus.halted, 1);
        chk("nomul_busy", bus.busy, 0);
`endif

        begin
            int m_pc, m_res;
            bit m_rv, m_h, m_inv;
            logic [5:0] op, fn;
            logic [7:0] rs, rt;
            logic [15:0] im;
            logic [25:0] jt;
            do_reset();
            m_pc = 12;
            m_res = 0;
            for (int n = 0; n < 300; n++) begin
                op = opl[$urandom_range(0, 8)];
                if ($urandom_range(0, 19) == 0) op = 6'($urandom_range(0, 63));
                fn = fnl[$urandom_range(0, 6)];
                if ($urandom_range(0, 19) == 0) fn = 6'($urandom_range(0, 63));
`ifdef EXEC_MUL_EN
                if (fn == 6'h18) fn = 6'h3F;
`endif
                rs = 8'($urandom_range(0, 255));
                rt = ($urandom_range(0, 3) == 0) ? rs : 8'($urandom_range(0, 255));
                im = 16'($urandom_range(0, 65535));
                jt = 26'($urandom());
                issue(op, fn, rs, rt, im, jt);
                ref_step(op, fn, rs, rt, im, jt, m_pc, m_res, m_rv, m_h, m_inv);
                chk($sformatf("rnd%0d_pc", n), bus.pc, m_pc);
                chk($sformatf("rnd%0d_result", n), bus.result, m_res);
                chk($sformatf("rnd%0d_rv", n), bus.result_valid, m_rv);
                chk($sformatf("rnd%0d_halted", n), bus.halted, m_h);
                chk($sformatf("rnd%0d_inv", n), bus.instruction_invalid, m_inv);
                if (m_h) begin
                    do_reset();
                    m_pc = 12;
                    m_res = 0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
